// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths, requester ids and response tag for the memory port arbiter.
// Data/address widths can be overridden by defining ADDR_W/DATA_W first.
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef DATA_W
`define DATA_W 64
`endif

package mem_port_arbiter_pkg;

  localparam int ADDR_W = `ADDR_W;
  localparam int DATA_W = `DATA_W;
  localparam int BE_W   = DATA_W / 8;

  typedef enum logic {
    REQ_DATA  = 1'b0,
    REQ_FETCH = 1'b1
  } req_id_e;

  typedef struct packed {
    logic valid;
    logic is_fetch;
  } tag_t;

  function automatic tag_t kill_tag(tag_t t, logic kill);
    tag_t r;
    r = t;
    if (kill && t.is_fetch) r.valid = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory bus bundle for the arbiter.
// slave = arbiter side, master = requesters plus memory.
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_kill;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic [ADDR_W-1:0] dm_addr;
  logic [BE_W-1:0]   dm_we;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [BE_W-1:0]   mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, if_kill,
    input  dm_req, dm_addr, dm_we, dm_wdata,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_addr, mem_we, mem_wdata
  );

  modport master (
    output if_req, if_addr, if_kill,
    output dm_req, dm_addr, dm_we, dm_wdata,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_resp_tag_pipe.sv
// Tag shift register matching the memory read latency.
// A flush drops every in-flight fetch tag, including the one entering.
module resp_tag_pipe
  import mem_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rstn,
  input  tag_t tag_i,
  input  logic kill_i,
  output tag_t tag_o
);

  tag_t [DEPTH-1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d[0] = kill_tag(tag_i, kill_i);
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = kill_tag(pipe_q[i-1], kill_i);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pipe_q <= '0;
    else       pipe_q <= pipe_d;
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between fetch and load/store.
// Data wins collisions until its streak would starve a waiting fetch.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int LOAD_LATENCY    = 1,
  parameter int MAX_DATA_STREAK = 4
) (
  input logic               clk,
  input logic               rstn,
  mem_port_arbiter_if.slave bus
);

  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

  logic [SW-1:0] streak_q, streak_d;
  logic          fetch_win;
  logic          if_gnt;
  logic          dm_gnt;
  req_id_e       gnt_id;
  tag_t          tag_in;
  tag_t          tag_out;

  always_comb begin
    fetch_win = bus.if_req &&
                (!bus.dm_req || streak_q == STREAK_MAX);
    if_gnt = rstn && fetch_win;
    dm_gnt = rstn && bus.dm_req && !fetch_win;
    gnt_id = if_gnt ? REQ_FETCH : REQ_DATA;
  end

  assign bus.if_gnt = if_gnt;
  assign bus.dm_gnt = dm_gnt;

  // Idle and fetch both present the fetch address as a read.
  always_comb begin
    bus.mem_addr  = bus.if_addr;
    bus.mem_we    = '0;
    bus.mem_wdata = '0;
    unique case (1'b1)
      !rstn: bus.mem_addr = '0;
      dm_gnt: begin
        bus.mem_addr  = bus.dm_addr;
        bus.mem_we    = bus.dm_we;
        bus.mem_wdata = bus.dm_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    streak_d = streak_q;
    if (if_gnt || !bus.if_req) begin
      streak_d = '0;
    end else if (dm_gnt && streak_q != STREAK_MAX) begin
      streak_d = streak_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) streak_q <= '0;
    else       streak_q <= streak_d;
  end

  always_comb begin
    tag_in.valid    = if_gnt || (dm_gnt && bus.dm_we == '0);
    tag_in.is_fetch = (gnt_id == REQ_FETCH);
  end

  resp_tag_pipe #(
    .DEPTH (LOAD_LATENCY)
  ) u_tags (
    .clk    (clk),
    .rstn   (rstn),
    .tag_i  (tag_in),
    .kill_i (bus.if_kill),
    .tag_o  (tag_out)
  );

  always_comb begin
    bus.if_rvalid = tag_out.valid && tag_out.is_fetch;
    bus.dm_rvalid = tag_out.valid && !tag_out.is_fetch;
    bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
    bus.dm_rdata  = bus.dm_rvalid ? bus.mem_rdata : '0;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency memory between the instruction-fetch requester and the data load/store requester.
- Lets the core run against a unified instruction/data memory instead of dual read ports.
- Data accesses have priority. A streak counter stops the data side from starving fetch.
- Tags every read so each requester gets only its own read data, with kill support for fetch reads that are still in flight after a flush.

Parameters:
- LOAD_LATENCY, 1: cycles from grant cycle to read data valid on mem_rdata (legal range ≥1).
- MAX_DATA_STREAK, 4: consecutive data grants allowed while fetch waits before fetch is forced a grant (legal range ≥1).

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- if_req  input  1  fetch read request
- if_addr  input  `ADDR_W  fetch address
- if_kill  input  1  flush: drop all in-flight fetch reads
- if_gnt  output  1  fetch request accepted this cycle
- if_rvalid  output  1  fetch read data valid
- if_rdata  output  `DATA_W  fetch read data
- dm_req  input  1  data request (read or write)
- dm_addr  input  `ADDR_W  data address
- dm_we  input  `DATA_W/8  byte write enables; all-zero means read
- dm_wdata  input  `DATA_W  store data
- dm_gnt  output  1  data request accepted this cycle
- dm_rvalid  output  1  load data valid
- dm_rdata  output  `DATA_W  load data
- mem_addr  output  `ADDR_W  memory address
- mem_we  output  `DATA_W/8  memory byte write enables
- mem_wdata  output  `DATA_W  memory store data
- mem_rdata  input  `DATA_W  memory read data, LOAD_LATENCY cycles after the address

Behaviour:
- Clock and reset: single clock domain, clk rising edge. rstn is asynchronous and active-low.
- Reset state:
  - tag pipeline cleared (all slots invalid), streak counter = 0;
  - while rstn=0: if_gnt=0, dm_gnt=0, mem_we=0, if_rvalid=0, dm_rvalid=0;
  - mem_addr, mem_wdata, if_rdata and dm_rdata are don't-care during reset, and are driven 0 by the implementation.
- Grant (combinational, same cycle as the request):
  - only dm_req → data granted;
  - only if_req → fetch granted;
  - both requesting → data granted, unless streak == MAX_DATA_STREAK, in which case fetch is granted;
  - neither requesting → idle: mem_we=0, mem_addr = if_addr.
- Memory drive: mem_addr, mem_we and mem_wdata are muxed from the granted requester. A fetch grant forces mem_we=0.
- Streak counter:
  - increments on a data grant while if_req=1, saturating at MAX_DATA_STREAK;
  - clears on a fetch grant or when if_req=0;
  - width is clog2(MAX_DATA_STREAK+1).
- Tag pipeline (LOAD_LATENCY stages, each stage {valid, is_fetch}):
  - stage 0 is loaded with valid=1 on a fetch grant, or on a data grant with dm_we==0;
  - a data store (dm_we≠0) loads valid=0: stores produce no response;
  - the pipeline shifts every cycle.
- Response:
  - at the last stage, if valid and is_fetch: if_rvalid=1 and if_rdata=mem_rdata;
  - if valid and not is_fetch: dm_rvalid=1 and dm_rdata=mem_rdata;
  - the rdata output that is not selected is held at 0.
  - Latency: rvalid is asserted exactly LOAD_LATENCY cycles after the grant cycle. One read can be issued per cycle, fully pipelined, with responses in issue order.
- Kill:
  - if_kill=1 clears valid on every fetch-tagged stage at the next edge, and on the stage being loaded that cycle if it is a fetch;
  - data-tagged entries are unaffected;
  - no if_rvalid appears for a killed read;
  - if_kill does not block a grant in the same cycle, but that grant's response is dropped.
- No backpressure: requesters must accept rvalid whenever it is asserted.
- Reset mid-operation: all in-flight tags are discarded immediately. No rvalid is ever produced for pre-reset requests.

Decomposition:
- Shared package (the common parameter header): `ADDR_W, `DATA_W, and a tag struct {logic valid; logic is_fetch;}. Requester-id encoding: FETCH=1, DATA=0.
- Sub-module resp_tag_pipe: the LOAD_LATENCY-deep tag shift register with selective fetch kill. The top level keeps the grant logic, memory mux and streak counter.

Test Plan:
- Fetch only, LOAD_LATENCY=1: if_req with if_addr=0x100 for 3 consecutive cycles → if_gnt=1 each cycle; if_rvalid=1 on cycles 1, 2, 3 with if_rdata equal to the memory content at 0x100 and the following addresses; dm_rvalid stays 0.
- Collision: if_req and dm_req both high, dm_we=0, dm_addr=0x2000 → dm_gnt=1, if_gnt=0, mem_addr=0x2000; one cycle later dm_rvalid=1 and if_rvalid=0.
- Starvation guard, MAX_DATA_STREAK=4: both requesters held high for 6 cycles → grant sequence D,D,D,D,F,D.
- Store: dm_we=8'hFF, dm_wdata=64'hDEADBEEF_CAFEF00D, dm_addr=0x40 → mem_we=8'hFF and mem_wdata passed through unchanged; no dm_rvalid; a later read of 0x40 returns the stored value.
- Kill, LOAD_LATENCY=2: fetch reads granted in cycles 0 and 1, if_kill=1 in cycle 1, data read granted in cycle 2 → no if_rvalid in cycles 2 or 3; dm_rvalid=1 in cycle 4.
- Reset mid-flight: rstn driven low for 1 cycle while 2 reads are outstanding → no rvalid from either requester after reset is released; streak counter reads 0.
